// File: rtl/hdma_pkg.sv
// Shared types and constants for the HDMA transfer engine.
package hdma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } hdma_state_e;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
    } hdma_entry_t;

    localparam int          ENTRY_W  = $bits(hdma_entry_t);
    localparam logic [7:0]  OPEN_BUS = 8'hFF;

endpackage

// File: rtl/hdma_req_fifo.sv
// Request FIFO: power-of-two depth, extra pointer MSB distinguishes full from empty.
// Head entry is visible combinationally so it can be loaded on the pop edge.
module hdma_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop on the same edge frees the slot a push into a full FIFO needs.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/hdma_xfer.sv
// HDMA byte mover: captures engine requests into a FIFO, reads each source byte
// (open-bus on timeout) and writes it to VRAM once the LCD releases the bus.
module hdma_xfer
    import hdma_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [7:0]  src_dout,
    input  logic        src_ready,
    input  logic        vram_busy,
    output logic        src_rd,
    output logic [15:0] src_rd_addr,
    output logic        vram_wr,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_din,
    output logic        cpu_stall,
    output logic        overrun
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    hdma_state_e   state_q, state_d;
    logic          req_prev_q, req_prev_d;
    logic [15:0]   last_src_q, last_src_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [7:0]    data_q, data_d;
    logic [12:0]   dst_q, dst_d;
    logic          src_rd_q, src_rd_d;
    logic [15:0]   src_rd_addr_q, src_rd_addr_d;
    logic [12:0]   vram_addr_q, vram_addr_d;
    logic [7:0]    vram_din_q, vram_din_d;
    logic          overrun_q, overrun_d;

    logic               capture;
    logic               drop;
    logic               wr_now;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    hdma_entry_t        cap_entry;
    hdma_entry_t        head;
    logic               unused_dst_hi;

    assign cap_entry     = '{src: src_addr, dst: dst_addr};
    assign head          = hdma_entry_t'(fifo_rd_data);
    assign unused_dst_hi = ^head.dst[15:13];

    hdma_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (capture),
        .push_data (cap_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        last_src_d    = last_src_q;
        wait_d        = wait_q;
        data_d        = data_q;
        dst_d         = dst_q;
        src_rd_d      = src_rd_q;
        src_rd_addr_d = src_rd_addr_q;
        vram_addr_d   = vram_addr_q;
        vram_din_d    = vram_din_q;
        overrun_d     = overrun_q;
        fifo_pop      = 1'b0;
        wr_now        = 1'b0;

        // A held request is only new when its source address moves.
        capture    = req && (!req_prev_q || (src_addr != last_src_q));
        req_prev_d = req;
        if (capture) begin
            last_src_d = src_addr;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end
            end
            READ: begin
                if (src_ready) begin
                    data_d   = src_dout;
                    state_d  = WRITE;
                    src_rd_d = 1'b0;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    data_d   = OPEN_BUS;
                    state_d  = WRITE;
                    src_rd_d = 1'b0;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            WRITE: begin
                if (!vram_busy) begin
                    wr_now      = 1'b1;
                    vram_addr_d = dst_q;
                    vram_din_d  = data_q;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifo_pop) begin
            state_d       = READ;
            src_rd_d      = 1'b1;
            src_rd_addr_d = head.src;
            dst_d         = head.dst[12:0];
            wait_d        = '0;
        end

        drop = capture && fifo_full && !fifo_pop;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (!req && fifo_empty && (state_q == IDLE)) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            req_prev_q    <= 1'b0;
            last_src_q    <= 16'h0000;
            wait_q        <= '0;
            data_q        <= 8'h00;
            dst_q         <= 13'h0000;
            src_rd_q      <= 1'b0;
            src_rd_addr_q <= 16'h0000;
            vram_addr_q   <= 13'h0000;
            vram_din_q    <= 8'h00;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_prev_q    <= req_prev_d;
            last_src_q    <= last_src_d;
            wait_q        <= wait_d;
            data_q        <= data_d;
            dst_q         <= dst_d;
            src_rd_q      <= src_rd_d;
            src_rd_addr_q <= src_rd_addr_d;
            vram_addr_q   <= vram_addr_d;
            vram_din_q    <= vram_din_d;
            overrun_q     <= overrun_d;
        end
    end

    // The write strobe follows vram_busy directly so a lock raised in the same
    // cycle still blocks it; address/data hold their last written values otherwise.
    assign vram_wr     = wr_now && reset_n;
    assign vram_addr   = vram_wr ? dst_q  : vram_addr_q;
    assign vram_din    = vram_wr ? data_q : vram_din_q;
    assign src_rd      = src_rd_q;
    assign src_rd_addr = src_rd_addr_q;
    assign overrun     = overrun_q;
    assign cpu_stall   = req || !fifo_empty || (state_q != IDLE);

endmodule
